// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage core.
//
// Purpose: detects load-use hazards between EX and ID, sequences
// multi-cycle load and mul/div stalls, and flushes on taken branches.
// Stall and flush controls are combinational from the state and the
// current inputs, so they take effect in the same cycle as the hazard.
// The block also keeps a saturating count of cycles with the PC held.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   ex_memread, ex_rd        load in EX and its destination register
//   id_rs1/id_rs2            source registers of the ID instruction
//   id_uses_rs1/id_uses_rs2  ID instruction really reads rs1/rs2
//   ex_muldiv                mul/div instruction in EX
//   ex_branch_taken          branch/jump resolved taken in EX
//   pc_pause, if_id_hold     hold PC and the IF/ID buffer
//   if_id_flush              clear the IF/ID buffer
//   id_ex_flush, id_ex_hold  bubble into / hold the ID/EX buffer
//   ex_mem_flush             bubble into EX/MEM
//   busy                     FSM not in IDLE
//   stall_count              saturating count of pc_pause cycles
module hazard_ctrl #(
  parameter int REG_AW            = 4,
  parameter int ZERO_REG_EN       = 1,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MULDIV_CYCLES     = 4,
  parameter int CNT_W             = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_muldiv,
  input  logic              ex_branch_taken,
  output logic              pc_pause,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              id_ex_hold,
  output logic              ex_mem_flush,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int MAXC = (LOAD_STALL_CYCLES > MULDIV_CYCLES) ? LOAD_STALL_CYCLES : MULDIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] LD_LOAD = CW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CW-1:0] MD_LOAD = CW'(MULDIV_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    MD_BUSY  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load_hz;
  logic          ld_grp, md_grp, br_grp;

  always_comb begin
    load_hz = ex_memread
              && ((ex_rd == id_rs1 && id_uses_rs1) || (ex_rd == id_rs2 && id_uses_rs2))
              && !((ZERO_REG_EN != 0) && (ex_rd == '0));
  end

  // Next state and stall-group selection
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_grp    = 1'b0;
    md_grp    = 1'b0;
    br_grp    = 1'b0;
    if (rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          // The flushed ID instruction cannot cause a stall, so the branch wins.
          if (ex_branch_taken) begin
            br_grp = 1'b1;
          end else if (ex_muldiv) begin
            md_grp    = 1'b1;
            cnt_nxt   = MD_LOAD;
            state_nxt = MD_BUSY;
          end else if (load_hz) begin
            ld_grp = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cnt_nxt   = LD_LOAD;
              state_nxt = LD_STALL;
            end
          end
        end
        LD_STALL: begin
          if (ex_branch_taken) begin
            br_grp    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            ld_grp  = 1'b1;
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) state_nxt = IDLE;
          end
        end
        MD_BUSY: begin
          // EX holds the mul/div, so a branch here is ignored. On the release
          // cycle ex_muldiv is still high and must not start a new sequence.
          if (cnt != '0) begin
            md_grp  = 1'b1;
            cnt_nxt = cnt - CW'(1);
          end else begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_pause     = ld_grp | md_grp;
    if_id_hold   = ld_grp | md_grp;
    if_id_flush  = br_grp;
    id_ex_flush  = ld_grp | br_grp;
    id_ex_hold   = md_grp;
    ex_mem_flush = md_grp;
    busy         = !rst && (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pc_pause && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  // Instance A: single-cycle load stall, zero register excluded, wide counter.
  localparam int A_L = 1, A_M = 4, A_Z = 1, A_CW = 16;
  // Instance B: three-cycle load stall, zero register hazards, 2-bit counter.
  localparam int B_L = 3, B_M = 3, B_Z = 0, B_CW = 2;

  logic       clk;
  logic       rst;
  logic       ex_memread;
  logic [3:0] ex_rd, id_rs1, id_rs2;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_muldiv, ex_branch_taken;

  logic        a_pc_pause, a_if_id_hold, a_if_id_flush, a_id_ex_flush, a_id_ex_hold, a_ex_mem_flush, a_busy;
  logic [15:0] a_stall_count;
  logic        b_pc_pause, b_if_id_hold, b_if_id_flush, b_id_ex_flush, b_id_ex_hold, b_ex_mem_flush, b_busy;
  logic [1:0]  b_stall_count;

  hazard_ctrl #(.REG_AW(4), .ZERO_REG_EN(A_Z), .LOAD_STALL_CYCLES(A_L),
                .MULDIV_CYCLES(A_M), .CNT_W(A_CW)) u_a (
    .clk(clk), .rst(rst), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_muldiv(ex_muldiv), .ex_branch_taken(ex_branch_taken),
    .pc_pause(a_pc_pause), .if_id_hold(a_if_id_hold), .if_id_flush(a_if_id_flush),
    .id_ex_flush(a_id_ex_flush), .id_ex_hold(a_id_ex_hold), .ex_mem_flush(a_ex_mem_flush),
    .busy(a_busy), .stall_count(a_stall_count));

  hazard_ctrl #(.REG_AW(4), .ZERO_REG_EN(B_Z), .LOAD_STALL_CYCLES(B_L),
                .MULDIV_CYCLES(B_M), .CNT_W(B_CW)) u_b (
    .clk(clk), .rst(rst), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_muldiv(ex_muldiv), .ex_branch_taken(ex_branch_taken),
    .pc_pause(b_pc_pause), .if_id_hold(b_if_id_hold), .if_id_flush(b_if_id_flush),
    .id_ex_flush(b_id_ex_flush), .id_ex_hold(b_id_ex_hold), .ex_mem_flush(b_ex_mem_flush),
    .busy(b_busy), .stall_count(b_stall_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model state: remaining load-stall cycles after the first,
  // remaining mul/div EX residency cycles after the first, stall count.
  int a_ld = 0, a_md = 0, a_sc = 0;
  int b_ld = 0, b_md = 0, b_sc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected controls packed as {pc_pause, if_id_hold, if_id_flush,
  // id_ex_flush, id_ex_hold, ex_mem_flush, busy}.
  task automatic model(input int L, input int M, input int z, input int smax,
                       input int ld, input int md, input int sc,
                       output logic [6:0] e, output int nld, output int nmd, output int nsc);
    bit hz, lds, mds, brs;
    hz  = ex_memread && ((ex_rd == id_rs1 && id_uses_rs1) || (ex_rd == id_rs2 && id_uses_rs2))
          && !(z != 0 && ex_rd == 0);
    lds = 0; mds = 0; brs = 0;
    nld = ld; nmd = md;
    if (rst) begin
      nld = 0; nmd = 0;
    end else if (md > 0) begin
      mds = (md > 1);          // last residency cycle releases the mul/div
      nmd = md - 1;
    end else if (ld > 0) begin
      if (ex_branch_taken) begin brs = 1; nld = 0; end
      else begin lds = 1; nld = ld - 1; end
    end else if (ex_branch_taken) begin
      brs = 1;
    end else if (ex_muldiv) begin
      mds = 1; nmd = M - 1;
    end else if (hz) begin
      lds = 1; nld = L - 1;
    end
    e = {lds | mds, lds | mds, brs, lds | brs, mds, mds, !rst && (ld > 0 || md > 0)};
    if (rst) nsc = 0;
    else if ((lds || mds) && sc < smax) nsc = sc + 1;
    else nsc = sc;
  endtask

  task automatic cyc();
    logic [6:0] ea, eb;
    int nla, nma, nsa, nlb, nmb, nsb;
    #1;
    model(A_L, A_M, A_Z, (1 << A_CW) - 1, a_ld, a_md, a_sc, ea, nla, nma, nsa);
    model(B_L, B_M, B_Z, (1 << B_CW) - 1, b_ld, b_md, b_sc, eb, nlb, nmb, nsb);
    chk("a_ctl", {25'd0, a_pc_pause, a_if_id_hold, a_if_id_flush, a_id_ex_flush,
                  a_id_ex_hold, a_ex_mem_flush, a_busy}, {25'd0, ea});
    chk("a_stall_count", {16'd0, a_stall_count}, a_sc);
    chk("b_ctl", {25'd0, b_pc_pause, b_if_id_hold, b_if_id_flush, b_id_ex_flush,
                  b_id_ex_hold, b_ex_mem_flush, b_busy}, {25'd0, eb});
    chk("b_stall_count", {30'd0, b_stall_count}, b_sc);
    @(posedge clk);
    a_ld = nla; a_md = nma; a_sc = nsa;
    b_ld = nlb; b_md = nmb; b_sc = nsb;
    #1;
  endtask

  task automatic clr();
    ex_memread = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_muldiv = 0; ex_branch_taken = 0;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst = 1; clr();
    @(posedge clk); #1;
    cyc();                                    // reset state with rst still high
    rst = 0;
    idle(1);

    // Load-use on rs2
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    cyc();
    chk("a_count_after_load_use", {16'd0, a_stall_count}, 32'd1);
    idle(4);

    // Destination x0 (A excludes it, B does not), then an unused operand
    ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    cyc();
    idle(4);
    ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 0; id_rs2 = 7; id_uses_rs2 = 1;
    cyc();
    idle(4);

    // Multi-cycle load, then branch aborting it one cycle later
    ex_memread = 1; ex_rd = 2; id_rs1 = 2; id_uses_rs1 = 1;
    cyc(); clr(); cyc(); cyc(); cyc();
    ex_memread = 1; ex_rd = 2; id_rs1 = 2; id_uses_rs1 = 1;
    cyc(); clr();
    ex_branch_taken = 1;
    cyc();
    idle(3);

    // Mul/div held in EX for four cycles
    ex_muldiv = 1;
    for (int i = 0; i < 4; i++) cyc();
    idle(4);

    // Branch together with a load hazard in IDLE
    ex_memread = 1; ex_rd = 6; id_rs1 = 6; id_uses_rs1 = 1; ex_branch_taken = 1;
    cyc();
    idle(2);

    // Saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      ex_memread = 1; ex_rd = 4; id_rs2 = 4; id_uses_rs2 = 1;
      cyc();
      idle(3);
    end
    chk("b_count_saturated", {30'd0, b_stall_count}, 32'd3);

    // Reset during MD_BUSY
    ex_muldiv = 1;
    cyc(); cyc();
    rst = 1;
    cyc();
    rst = 0; clr();
    chk("a_count_after_reset", {16'd0, a_stall_count}, 32'd0);
    chk("b_count_after_reset", {30'd0, b_stall_count}, 32'd0);
    idle(2);

    // Randomized traffic over a small register space to hit hazards often
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(99) < 2);
      ex_memread      = ($urandom_range(99) < 50);
      ex_rd           = 4'($urandom_range(3));
      id_rs1          = 4'($urandom_range(3));
      id_rs2          = 4'($urandom_range(3));
      id_uses_rs1     = 1'($urandom_range(1));
      id_uses_rs2     = 1'($urandom_range(1));
      ex_muldiv       = ($urandom_range(99) < 10);
      ex_branch_taken = ($urandom_range(99) < 15);
      cyc();
    end
    rst = 0;
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
